fft_frame_unload: RTL and testbench
===================================

# fft_frame_unload

Output stage that directly follows the parallel radix-2 butterfly. Captures each complete N-sample complex frame presented on the butterfly's wide output bus when its enable is high, holds it in a two-bank ping-pong buffer, and emits the samples one per beat on a valid/ready stream. The samples leave in bit-reversed index order (natural frequency order) or in bus order, depending on configuration.

## Interface
- N, default 8: complex samples per frame; power of two, ≥2.
- DATA_WIDTH, default 16: bits per real or imaginary component, two's complement.
- IW (local), value $clog2(N): sample index width.

- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous and active-high.
- cplx_data_in  in  DATA_WIDTH*2*N  frame bus. Sample k real is at [DATA_WIDTH*(2k+1)-1 -: DATA_WIDTH]; sample k imag is at [DATA_WIDTH*(2k+2)-1 -: DATA_WIDTH]. Bus may be Z while en_in=0.
- en_in  in  1  frame strobe from butterfly en_out; one frame per high cycle.
- frame_ready  out  1  at least one bank is free, or a bank is being freed this cycle.
- data_out  out  2*DATA_WIDTH  current sample: real in [DATA_WIDTH-1:0], imag in the upper half.
- index_out  out  IW  bus index k of the sample on data_out.
- valid_out  out  1  data_out is valid.
- ready_in  in  1  downstream accepts.
- last_out  out  1  data_out holds the final sample of its frame.
- overflow  out  1  sticky; set when a frame is dropped.

## Operation
- Two banks, each N×2×DATA_WIDTH, each with a full flag. wr_sel selects the next bank to fill. rd_sel selects the bank being drained. rd_cnt (IW bits) is the beat counter.
- Capture: on an edge where en_in=1 and bank[wr_sel] is empty (or is being freed in this same cycle), store all N samples, set full, and toggle wr_sel.
- Drop: if en_in=1 and neither capture condition holds, discard the frame, set overflow, and leave banks and pointers unchanged.
- en_in=0: bus contents are ignored (tolerates Z).
- Drain: valid_out = full[rd_sel]. The beat index is bitrev(rd_cnt) or rd_cnt (see Configuration). data_out, index_out and last_out are combinational from bank[rd_sel], the index and rd_cnt.
- Handshake: a beat transfers when valid_out && ready_in, and rd_cnt then increments.
  - On the last beat (rd_cnt==N-1): clear full[rd_sel], toggle rd_sel, wrap rd_cnt to 0.
  - While valid_out && !ready_in: data_out, index_out and last_out are held stable.
- Simultaneous last-beat transfer and capture into the same bank is legal. The bank ends full with the new frame, and its rd_cnt restarts at 0.
- Arithmetic: none. Data is stored and forwarded bit-exact, with no rounding or scaling.

## Timing
- Reset values: valid_out=0, last_out=0, overflow=0, frame_ready=1, data_out=0, index_out=0. Both banks empty; wr_sel=rd_sel=0; rd_cnt=0. Bank contents are don't-care but are never presented while empty.
- Latency: frame captured at edge E → valid_out=1 with beat 0 in the cycle after E.
- Throughput: N beats per frame with ready_in held high. Back-to-back frames stream with no bubble; the first beat of the next bank follows the last beat of the previous one.
- Buffering: a frame arriving every N cycles is sustained indefinitely. Two frames can be buffered while ready_in is low; the third is dropped.
- Reset asserted mid-frame: on that edge all flags, pointers and overflow clear, and the partially drained frame is discarded. en_in on the reset edge is ignored.

## Configuration
- FFT_BITREV_EN defined: beat j emits bus sample bitrev_IW(j), the natural-order output of a decimation-in-frequency stage.
- Not defined: beat j emits bus sample j, in bus order.
- index_out always reports the bus index actually emitted.

## Structure
- Shared package fft_pkg:
  - function bitrev(idx, width);
  - cplx_t packed struct {imag, real} of DATA_WIDTH each;
  - helper that extracts sample k from the frame bus.
  The butterfly stage reuses these helpers.
- Sub-module fft_frame_bank: one bank with a load strobe, full flag, set/clear, and indexed read port. Instantiated twice; pointers and handshake stay in the top.

## Test plan
Setup for all scenarios: N=8, DATA_WIDTH=16; sample k = {imag=-k, real=0x100+k}.

1. Single frame, FFT_BITREV_EN defined, ready_in=1: en_in pulse → valid_out high for exactly 8 cycles starting the next cycle. index_out sequence is 0,4,2,6,1,5,3,7; real values are 0x100,0x104,…; last_out high only on beat 7.
2. Same stimulus without the macro: index_out is 0..7 in order, and data_out real is 0x100..0x107.
3. Backpressure: toggle ready_in 1,0,0,1,… → data_out is held across stall cycles. All 8 samples arrive once each, in order, and overflow stays 0.
4. Overflow: ready_in=0 with three en_in pulses, frames A, B, C → overflow=1 and frame_ready=0. With ready_in=1 afterwards, only A then B drain (16 beats) and C never appears.
5. Back-to-back: en_in every 8 cycles for 4 frames with ready_in=1 → 32 consecutive valid beats with no gap and overflow=0. Includes a cycle where the last beat of one bank coincides with a capture into that same bank.
6. Reset at beat 3 of a frame → the next cycle has valid_out=0 and overflow=0. A fresh frame afterwards drains from beat 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT helpers: bit reversal, complex sample type and frame-bus sample extraction.
// Also used by the butterfly stage.
package fft_pkg;

  localparam int IDX_W_MAX = 16;
  localparam int CPLX_DW   = 16;
  localparam int FRAME_MAX = 64;

  // Packed so that {im, re} matches the frame-bus and output-word layout (re in the low half).
  typedef struct packed {
    logic signed [CPLX_DW-1:0] im;
    logic signed [CPLX_DW-1:0] re;
  } cplx_t;

  function automatic logic [IDX_W_MAX-1:0] bitrev(input logic [IDX_W_MAX-1:0] idx,
                                                   input int width);
    logic [IDX_W_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < IDX_W_MAX; i++)
      if (i < width) r[i] = idx[width-1-i];
    return r;
  endfunction

  function automatic cplx_t frame_sample(input logic [FRAME_MAX*2*CPLX_DW-1:0] bus,
                                         input int k);
    return bus[k*2*CPLX_DW +: 2*CPLX_DW];
  endfunction

endpackage

// File: rtl/fft_frame_unload_if.sv
// Frame-in / sample-stream-out bundle of the FFT output stage.
interface fft_frame_unload_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16
);
  localparam int IW = $clog2(N);

  logic [DATA_WIDTH*2*N-1:0] cplx_data_in;
  logic                      en_in;
  logic                      frame_ready;
  logic [2*DATA_WIDTH-1:0]   data_out;
  logic [IW-1:0]             index_out;
  logic                      valid_out;
  logic                      ready_in;
  logic                      last_out;
  logic                      overflow;

  modport master (
    output cplx_data_in, en_in, ready_in,
    input  frame_ready, data_out, index_out, valid_out, last_out, overflow
  );

  modport slave (
    input  cplx_data_in, en_in, ready_in,
    output frame_ready, data_out, index_out, valid_out, last_out, overflow
  );
endinterface

// File: rtl/fft_frame_bank.sv
// One frame buffer bank: whole-frame load, full flag, indexed sample read.
module fft_frame_bank #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16,
  parameter int IW         = $clog2(N)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic                             clr,
  input  logic [N-1:0][2*DATA_WIDTH-1:0]   din,
  input  logic [IW-1:0]                    rd_idx,
  output logic [2*DATA_WIDTH-1:0]          rd_data,
  output logic                             full
);
  logic [N-1:0][2*DATA_WIDTH-1:0] mem;

  // Contents are never presented while empty, so they carry no reset.
  always_ff @(posedge clk)
    if (load) mem <= din;

  // Load beats clear so a refill on the draining bank's last beat keeps it full.
  always_ff @(posedge clk)
    if (rst)       full <= 1'b0;
    else if (load) full <= 1'b1;
    else if (clr)  full <= 1'b0;

  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/fft_frame_unload.sv
// Ping-pong unload stage after the parallel butterfly; streams one sample per beat.
// Define FFT_BITREV_EN for bit-reversed (natural-frequency) beat order, else bus order.
module fft_frame_unload
  import fft_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  fft_frame_unload_if.slave  io
);
  localparam int IW = $clog2(N);
  localparam int SW = 2*DATA_WIDTH;

  logic [N-1:0][SW-1:0] frame;
  logic                 wr_sel, rd_sel;
  logic [IW-1:0]        rd_cnt, beat_idx;
  logic                 overflow_q;
  logic [1:0]           full, load, clr;
  logic [1:0][SW-1:0]   rd_data;
  logic                 valid, last_beat, xfer, capture, drop;

  assign frame = io.cplx_data_in;

`ifdef FFT_BITREV_EN
  assign beat_idx = IW'(bitrev(IDX_W_MAX'(rd_cnt), IW));
`else
  assign beat_idx = rd_cnt;
`endif

  always_comb begin
    valid     = full[rd_sel];
    last_beat = (rd_cnt == IW'(N-1));
    xfer      = valid & io.ready_in;
    clr       = '0;
    clr[rd_sel] = xfer & last_beat;
    // A bank freed on this edge may be refilled on the same edge.
    capture   = io.en_in & (~full[wr_sel] | clr[wr_sel]);
    drop      = io.en_in & ~capture;
    load      = '0;
    load[wr_sel] = capture;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank #(.N(N), .DATA_WIDTH(DATA_WIDTH), .IW(IW)) u_bank (
      .clk     (clk),
      .rst     (rst),
      .load    (load[b]),
      .clr     (clr[b]),
      .din     (frame),
      .rd_idx  (beat_idx),
      .rd_data (rd_data[b]),
      .full    (full[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      rd_cnt     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (capture) wr_sel <= ~wr_sel;
      if (drop)    overflow_q <= 1'b1;
      if (xfer) begin
        if (last_beat) begin
          rd_cnt <= '0;
          rd_sel <= ~rd_sel;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  assign io.valid_out   = valid;
  assign io.data_out    = valid ? rd_data[rd_sel] : '0;
  assign io.index_out   = valid ? beat_idx : '0;
  assign io.last_out    = valid & last_beat;
  assign io.frame_ready = ~(&full) | (xfer & last_beat);
  assign io.overflow    = overflow_q;

  a_hold_on_stall: assert property (@(posedge clk) disable iff (rst)
    (io.valid_out && !io.ready_in) |=> ($stable(io.data_out) && $stable(io.index_out)
                                        && $stable(io.last_out)));
endmodule

// File: tb/tb_fft_frame_unload.sv
// Directed bench for fft_frame_unload (N=8, 16-bit); sample k = {imag=-k, real=base+k}.
module tb_fft_frame_unload;
  import fft_pkg::*;

  localparam int N  = 8;
  localparam int DW = 16;

`ifdef FFT_BITREV_EN
  localparam int ORD [0:7] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
  localparam int ORD [0:7] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  fft_frame_unload_if #(.N(N), .DATA_WIDTH(DW)) io ();
  fft_frame_unload #(.N(N), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .io(io));

  function automatic logic [31:0] smp(input int base, input int k);
    cplx_t s;
    s.re = 16'(base + k);
    s.im = 16'(-k);
    return s;
  endfunction

  task automatic load_frame(input int base);
    for (int k = 0; k < N; k++) io.cplx_data_in[32*k +: 32] = smp(base, k);
    io.en_in = 1'b1;
  endtask

  task automatic idle_bus;
    io.en_in        = 1'b0;
    io.cplx_data_in = 'z;
  endtask

  task automatic test_reset;
    rst = 1'b1; io.ready_in = 1'b1; idle_bus();
    repeat (2) @(negedge clk);
    vecs++; if (io.valid_out !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b exp 0", io.valid_out); end
    vecs++; if (io.last_out !== 1'b0) begin errs++; $display("FAIL rst_last: got %b exp 0", io.last_out); end
    vecs++; if (io.overflow !== 1'b0) begin errs++; $display("FAIL rst_ovf: got %b exp 0", io.overflow); end
    vecs++; if (io.frame_ready !== 1'b1) begin errs++; $display("FAIL rst_frdy: got %b exp 1", io.frame_ready); end
    vecs++; if (io.data_out !== 32'h0) begin errs++; $display("FAIL rst_data: got %h exp 0", io.data_out); end
    vecs++; if (io.index_out !== 3'd0) begin errs++; $display("FAIL rst_idx: got %0d exp 0", io.index_out); end
    rst = 1'b0;
    @(negedge clk);
    vecs++; if (io.valid_out !== 1'b0) begin errs++; $display("FAIL post_rst_valid: got %b exp 0", io.valid_out); end
  endtask

  task automatic test_single;
    io.ready_in = 1'b1;
    load_frame(16'h100);
    @(negedge clk);
    idle_bus();
    for (int j = 0; j < N; j++) begin
      vecs++; if (io.valid_out !== 1'b1) begin errs++; $display("FAIL single_valid[%0d]: got %b exp 1", j, io.valid_out); end
      vecs++; if (io.index_out !== 3'(ORD[j])) begin errs++; $display("FAIL single_idx[%0d]: got %0d exp %0d", j, io.index_out, ORD[j]); end
      vecs++; if (io.data_out !== smp(16'h100, ORD[j])) begin errs++; $display("FAIL single_data[%0d]: got %h exp %h", j, io.data_out, smp(16'h100, ORD[j])); end
      vecs++; if (io.last_out !== (j == N-1)) begin errs++; $display("FAIL single_last[%0d]: got %b exp %b", j, io.last_out, (j == N-1)); end
      @(negedge clk);
    end
    vecs++; if (io.valid_out !== 1'b0) begin errs++; $display("FAIL single_end_valid: got %b exp 0", io.valid_out); end
  endtask

  task automatic test_backpressure;
    int got = 0;
    logic stalled = 1'b0;
    logic [31:0] hd;
    logic [2:0]  hi;
    logic        hl;
    hd = '0; hi = '0; hl = 1'b0;
    load_frame(16'h100);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      idle_bus();
      if (stalled) begin
        vecs++; if (io.data_out !== hd || io.index_out !== hi || io.last_out !== hl) begin
          errs++; $display("FAIL bp_hold[%0d]: got %h/%0d/%b exp %h/%0d/%b", c, io.data_out, io.index_out, io.last_out, hd, hi, hl);
        end
      end
      io.ready_in = ((c % 3) == 0);
      stalled = io.valid_out && !io.ready_in;
      hd = io.data_out; hi = io.index_out; hl = io.last_out;
      if (io.valid_out && io.ready_in) begin
        vecs++;
        if (got >= N) begin
          errs++; $display("FAIL bp_extra: got beat %0d exp none", got);
        end else if (io.index_out !== 3'(ORD[got]) || io.data_out !== smp(16'h100, ORD[got]) || io.last_out !== (got == N-1)) begin
          errs++; $display("FAIL bp_beat[%0d]: got %0d/%h/%b exp %0d/%h/%b", got, io.index_out, io.data_out, io.last_out, ORD[got], smp(16'h100, ORD[got]), (got == N-1));
        end
        got++;
      end
    end
    vecs++; if (got != N) begin errs++; $display("FAIL bp_count: got %0d exp %0d", got, N); end
    vecs++; if (io.overflow !== 1'b0) begin errs++; $display("FAIL bp_ovf: got %b exp 0", io.overflow); end
    io.ready_in = 1'b1;
  endtask

  task automatic test_back_to_back;
    int fno = 0;
    io.ready_in = 1'b1;
    for (int c = 0; c <= 33; c++) begin
      @(negedge clk);
      idle_bus();
      if (c >= 1 && c <= 32) begin
        int b, f, j;
        b = c - 1; f = b / 8; j = b % 8;
        vecs++; if (io.valid_out !== 1'b1 || io.index_out !== 3'(ORD[j]) || io.data_out !== smp(16'h100*(f+1), ORD[j])) begin
          errs++; $display("FAIL b2b_beat[%0d]: got %b/%0d/%h exp 1/%0d/%h", b, io.valid_out, io.index_out, io.data_out, ORD[j], smp(16'h100*(f+1), ORD[j]));
        end
      end else if (c == 33) begin
        vecs++; if (io.valid_out !== 1'b0) begin errs++; $display("FAIL b2b_end_valid: got %b exp 0", io.valid_out); end
      end
      if (c == 0 || c == 1 || c == 8 || c == 16) begin
        load_frame(16'h100*(fno+1));
        fno++;
      end
      if (c == 8 || c == 16) begin
        #1;
        vecs++; if (io.last_out !== 1'b1 || io.frame_ready !== 1'b1) begin
          errs++; $display("FAIL b2b_refill[%0d]: got last=%b frdy=%b exp 1/1", c, io.last_out, io.frame_ready);
        end
      end
    end
    vecs++; if (io.overflow !== 1'b0) begin errs++; $display("FAIL b2b_ovf: got %b exp 0", io.overflow); end
  endtask

  task automatic test_overflow;
    io.ready_in = 1'b0;
    @(negedge clk); load_frame(16'h100);
    @(negedge clk); load_frame(16'h200);
    @(negedge clk); #1;
    vecs++; if (io.frame_ready !== 1'b0 || io.overflow !== 1'b0) begin
      errs++; $display("FAIL ovf_two_full: got frdy=%b ovf=%b exp 0/0", io.frame_ready, io.overflow);
    end
    load_frame(16'h300);
    @(negedge clk);
    idle_bus();
    vecs++; if (io.overflow !== 1'b1) begin errs++; $display("FAIL ovf_set: got %b exp 1", io.overflow); end
    vecs++; if (io.frame_ready !== 1'b0) begin errs++; $display("FAIL ovf_frdy: got %b exp 0", io.frame_ready); end
    io.ready_in = 1'b1;
    for (int b = 0; b < 2*N; b++) begin
      int base;
      base = (b < N) ? 16'h100 : 16'h200;
      vecs++; if (io.valid_out !== 1'b1 || io.data_out !== smp(base, ORD[b%8]) || io.index_out !== 3'(ORD[b%8])) begin
        errs++; $display("FAIL ovf_drain[%0d]: got %b/%h/%0d exp 1/%h/%0d", b, io.valid_out, io.data_out, io.index_out, smp(base, ORD[b%8]), ORD[b%8]);
      end
      @(negedge clk);
    end
    vecs++; if (io.valid_out !== 1'b0) begin errs++; $display("FAIL ovf_no_c: got valid %b data %h exp 0", io.valid_out, io.data_out); end
    vecs++; if (io.overflow !== 1'b1) begin errs++; $display("FAIL ovf_sticky: got %b exp 1", io.overflow); end
  endtask

  task automatic test_reset_mid;
    io.ready_in = 1'b1;
    load_frame(16'h600);
    @(negedge clk);
    idle_bus();
    for (int j = 0; j < 3; j++) @(negedge clk);
    vecs++; if (io.index_out !== 3'(ORD[3]) || io.data_out !== smp(16'h600, ORD[3])) begin
      errs++; $display("FAIL rmid_beat3: got %0d/%h exp %0d/%h", io.index_out, io.data_out, ORD[3], smp(16'h600, ORD[3]));
    end
    rst = 1'b1;
    load_frame(16'h700);
    @(negedge clk);
    rst = 1'b0;
    idle_bus();
    vecs++; if (io.valid_out !== 1'b0) begin errs++; $display("FAIL rmid_valid: got %b exp 0", io.valid_out); end
    vecs++; if (io.overflow !== 1'b0) begin errs++; $display("FAIL rmid_ovf: got %b exp 0", io.overflow); end
    vecs++; if (io.frame_ready !== 1'b1) begin errs++; $display("FAIL rmid_frdy: got %b exp 1", io.frame_ready); end
    @(negedge clk);
    vecs++; if (io.valid_out !== 1'b0) begin errs++; $display("FAIL rmid_en_ignored: got %b exp 0", io.valid_out); end
    load_frame(16'h500);
    @(negedge clk);
    idle_bus();
    for (int j = 0; j < N; j++) begin
      vecs++; if (io.valid_out !== 1'b1 || io.index_out !== 3'(ORD[j]) || io.data_out !== smp(16'h500, ORD[j])) begin
        errs++; $display("FAIL rmid_fresh[%0d]: got %b/%0d/%h exp 1/%0d/%h", j, io.valid_out, io.index_out, io.data_out, ORD[j], smp(16'h500, ORD[j]));
      end
      @(negedge clk);
    end
    vecs++; if (io.valid_out !== 1'b0) begin errs++; $display("FAIL rmid_end_valid: got %b exp 0", io.valid_out); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
